// File: rtl/roller_pkg.sv
// Shared helpers for the roller_stream block: chunk-count and counter-width arithmetic.
// Latency: none (elaboration-time constant functions only).
// Backpressure: not applicable.
package roller_pkg;

    // Number of chunks needed to cover a lanes with chunks of b lanes.
    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Bits needed to count 0..x-1, never less than one so a single-chunk
    // configuration still gets a legal counter.
    function automatic int clog2_min1(input int x);
        return (x <= 2) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/roller_stream_if.sv
// Bundles the input-vector and output-chunk handshakes of roller_stream.
// Latency: none (wires only).
// Backpressure: valid/ready on both sides; slave = the roller, master = its neighbours.
// Optional signals data_out_idx / data_out_last exist only with ROLLER_STREAM_IDX_EN.
interface roller_stream_if
    import roller_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM        = 8,
    parameter int ROLL_NUM   = 2
);
    localparam int CYCLES = ceil_div(NUM, ROLL_NUM);
    localparam int IW     = clog2_min1(CYCLES + 1);

    logic [DATA_WIDTH-1:0] data_in [NUM-1:0];
    logic                  data_in_valid;
    logic                  data_in_ready;
    logic [DATA_WIDTH-1:0] data_out [ROLL_NUM-1:0];
    logic                  data_out_valid;
    logic                  data_out_ready;
`ifdef ROLLER_STREAM_IDX_EN
    logic [IW-1:0]         data_out_idx;
    logic                  data_out_last;
`endif

    modport slave (
        input  data_in, data_in_valid, data_out_ready,
        output data_in_ready, data_out, data_out_valid
`ifdef ROLLER_STREAM_IDX_EN
        , output data_out_idx, data_out_last
`endif
    );

    modport master (
        output data_in, data_in_valid, data_out_ready,
        input  data_in_ready, data_out, data_out_valid
`ifdef ROLLER_STREAM_IDX_EN
        , input data_out_idx, data_out_last
`endif
    );

endinterface

// File: rtl/roller_chunk_sel.sv
// Combinational chunk mux: picks ROLL_NUM lanes of a NUM-lane vector for chunk i_k, highest lanes first.
// Latency: zero (pure combinational).
// Backpressure: none; the caller holds i_vec/i_k stable while stalled.
// Ports: i_vec (NUM lanes), i_k (chunk index), o_lanes (ROLL_NUM lanes, zero where the chunk runs off lane 0).
module roller_chunk_sel
    import roller_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM        = 8,
    parameter int ROLL_NUM   = 2,
    parameter int KW         = 2
) (
    input  logic [DATA_WIDTH-1:0] i_vec   [NUM-1:0],
    input  logic [KW-1:0]         i_k,
    output logic [DATA_WIDTH-1:0] o_lanes [ROLL_NUM-1:0]
);

    // Source lane for output lane i is NUM-ROLL_NUM-k*ROLL_NUM+i. Matching
    // against every real lane index keeps out-of-range sources (the tail
    // chunk's negative indices) naturally zero without any array overrun.
    always_comb begin
        for (int i = 0; i < ROLL_NUM; i++) begin
            o_lanes[i] = '0;
            for (int j = 0; j < NUM; j++) begin
                if (j == NUM - ROLL_NUM - int'(i_k) * ROLL_NUM + i)
                    o_lanes[i] = i_vec[j];
            end
        end
    end

endmodule

// File: rtl/roller_stream.sv
// Rolls each NUM-lane input vector out as ceil(NUM/ROLL_NUM) ROLL_NUM-lane chunks, highest lanes first.
// Latency: chunk 0 is valid the cycle after acceptance into an empty roller; back-to-back vectors are bubble-free.
// Backpressure: output stalls hold chunk/index; input ready drops only while the one-deep pending slot is full.
// Ports: clk, rst (sync, active-high), bus (roller_stream_if.slave: data_in/valid/ready, data_out/valid/ready,
//        plus data_out_idx/data_out_last when ROLLER_STREAM_IDX_EN is defined).
module roller_stream
    import roller_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM        = 8,
    parameter int ROLL_NUM   = 2
) (
    input  logic           clk,
    input  logic           rst,
    roller_stream_if.slave bus
);

    localparam int            CYCLES = ceil_div(NUM, ROLL_NUM);
    localparam int            KW     = clog2_min1(CYCLES);
    localparam int            IW     = clog2_min1(CYCLES + 1);
    localparam logic [KW-1:0] K_LAST = KW'(CYCLES - 1);

    logic [DATA_WIDTH-1:0] r_act_vec  [NUM-1:0];
    logic                  r_act_vld;
    logic [KW-1:0]         r_k;
    logic [DATA_WIDTH-1:0] r_pend_vec [NUM-1:0];
    logic                  r_pend_full;

    logic                  w_in_fire;
    logic                  w_out_fire;
    logic                  w_last;
    logic [DATA_WIDTH-1:0] w_lanes [ROLL_NUM-1:0];

    // Ready depends on the pending flag alone, so it never combinationally
    // follows data_out_ready.
    assign bus.data_in_ready  = !r_pend_full;
    assign bus.data_out_valid = r_act_vld;

    assign w_in_fire  = bus.data_in_valid && !r_pend_full;
    assign w_out_fire = r_act_vld && bus.data_out_ready;
    assign w_last     = (r_k == K_LAST);

    roller_chunk_sel #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM        (NUM),
        .ROLL_NUM   (ROLL_NUM),
        .KW         (KW)
    ) u_sel (
        .i_vec   (r_act_vec),
        .i_k     (r_k),
        .o_lanes (w_lanes)
    );

    // Idle output is forced to zero so nothing stale leaks once a vector drains.
    always_comb begin
        for (int i = 0; i < ROLL_NUM; i++)
            bus.data_out[i] = r_act_vld ? w_lanes[i] : '0;
    end

`ifdef ROLLER_STREAM_IDX_EN
    assign bus.data_out_idx  = IW'(r_k);
    assign bus.data_out_last = w_last && r_act_vld;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_act_vld   <= 1'b0;
            r_pend_full <= 1'b0;
            r_k         <= '0;
            for (int i = 0; i < NUM; i++) begin
                r_act_vec[i]  <= '0;
                r_pend_vec[i] <= '0;
            end
        end else if (!r_act_vld) begin
            // Empty roller: an accepted vector goes straight to ACTIVE.
            if (w_in_fire) begin
                r_act_vec <= bus.data_in;
                r_act_vld <= 1'b1;
                r_k       <= '0;
            end
        end else if (w_out_fire && w_last) begin
            // Final chunk leaving: refill ACTIVE on the same edge so the next
            // vector's chunk 0 follows with no idle cycle.
            r_k <= '0;
            if (r_pend_full)
                r_act_vec <= r_pend_vec;
            else if (w_in_fire)
                r_act_vec <= bus.data_in;
            else
                r_act_vld <= 1'b0;
            // Pending only stays full if it was refilled on this same edge.
            r_pend_full <= r_pend_full && w_in_fire;
            if (r_pend_full && w_in_fire)
                r_pend_vec <= bus.data_in;
        end else begin
            // Mid-vector: advance on a consumed chunk, park any new vector.
            if (w_out_fire)
                r_k <= r_k + KW'(1);
            if (w_in_fire) begin
                r_pend_vec  <= bus.data_in;
                r_pend_full <= 1'b1;
            end
        end
    end

endmodule
